ldm_stm_sequencer: RTL and testbench
====================================

// Module: ldm_stm_sequencer
// PURPOSE
//  Parametrised multi-register transfer sequencer for LDM/STM execution.
//  Latches the register list, base address and addressing mode on start.
//  Emits one register index plus memory address per accepted beat, lowest index first.
//  Computes the base writeback value; replaces the combinational list priority encoder.
// PARAMETERS
//  REG_COUNT   16  number of architectural registers / register-list bits
//  RIDX_W      4   register index width, clog2(REG_COUNT)
//  ADDR_WIDTH  32  memory address width
//  WORD_BYTES  4   address increment per transferred register
// PORTS
//  clk_in        in   1           clock, rising edge
//  reset_in      in   1           asynchronous, active-low reset
//  start_in      in   1           begin transfer; sampled only in IDLE
//  reg_list_in   in   REG_COUNT   register list, bit i = register i
//  base_addr_in  in   ADDR_WIDTH  base register value
//  mode_in       in   2           {P,U}: 00 DA, 01 IA, 10 DB, 11 IB
//  ready_in      in   1           memory stage accepts current beat
//  busy_out      out  1           sequencer in RUN or DONE
//  valid_out     out  1           reg_addr_out/mem_addr_out valid
//  reg_addr_out  out  RIDX_W      register index of current beat
//  mem_addr_out  out  ADDR_WIDTH  memory address of current beat
//  last_out      out  1           current beat is final beat
//  done_out      out  1           one-cycle pulse, transfer complete
//  wb_addr_out   out  ADDR_WIDTH  base writeback value, valid with done_out (LDM_STM_WRITEBACK_EN)
//  wb_en_out     out  1           writeback strobe, equals done_out (LDM_STM_WRITEBACK_EN)
// BEHAVIOUR
//  - Reset: state IDLE, all outputs 0, latched list/address/count cleared; reset mid-op aborts transfer, no done_out.
//  - FSM IDLE -> RUN on start_in with non-empty list; IDLE -> DONE on start_in with empty list.
//  - FSM RUN -> DONE on handshake (valid_out & ready_in) while last_out; DONE -> IDLE unconditionally after 1 cycle.
//  - Start cycle: latch list, N = popcount(list) (RIDX_W+1 bits), and first address.
//    IA: base; IB: base+WB; DA: base-N*WB+WB; DB: base-N*WB (WB = WORD_BYTES).
//  - Latency: start_in at cycle 0 -> valid_out high at cycle 1.
//  - RUN: valid_out=1; reg_addr_out = index of lowest set bit of latched list.
//  - Handshake: clear that bit; mem_addr_out += WB; next beat in following cycle.
//  - ready_in low: all beat outputs held stable, no state change.
//  - Addresses always ascend with register index in every mode (ARM ordering).
//  - last_out = valid_out & exactly one bit remaining.
//  - done_out: 1-cycle pulse in DONE state, i.e. the cycle after the last handshake (cycle 1 for an empty list).
//  - Empty list: no beats, valid_out never asserted, writeback = base unchanged.
//  - start_in while busy_out=1 ignored; inputs other than ready_in ignored outside the start cycle.
//  - All address arithmetic modulo 2^ADDR_WIDTH; wrap-around silent, no flag.
//  - busy_out = (state != IDLE).
// CONFIGURATION
//  - LDM_STM_WRITEBACK_EN defined: wb_addr_out/wb_en_out present.
//    IA/IB: base+N*WB; DA/DB: base-N*WB; wb_en_out pulses with done_out, wb_addr_out 0 otherwise.
//  - LDM_STM_WRITEBACK_EN undefined: both ports and writeback adder removed; all else identical.
// TESTING
//  - list 16'h8001, IA, base 0x1000, ready=1 -> r0@0x1000 then r15@0x1004 (last), done next cycle, wb 0x1008.
//  - list 16'h00F0, DB, base 0x2000 -> r4@0x1FF0, r5@0x1FF4, r6@0x1FF8, r7@0x1FFC; wb 0x1FF0.
//  - list 16'h0006, IB, base 0x1000, ready low 3 cycles on beat 1 -> r1@0x1004 held 3 cycles, then r2@0x1008.
//  - list 16'h0000, DA, start -> done_out at cycle 1, valid_out never high, wb = base.
//  - IB, base 0xFFFFFFFC, list 16'h0003 -> r0@0x00000000, r1@0x00000004 (wrap).
//  - reset_in low mid-RUN -> all outputs 0 asynchronously, no done_out; start during RUN ignored.

Source files
------------

// File: rtl/ldm_stm_sequencer_if.sv
// Handshake/bus bundle between the LDM/STM sequencer and its controller.
// LDM_STM_WRITEBACK_EN adds the base writeback signals.
interface ldm_stm_sequencer_if #(
  parameter int REG_COUNT  = 16,
  parameter int RIDX_W     = 4,
  parameter int ADDR_WIDTH = 32
);
  logic                  start_in;
  logic [REG_COUNT-1:0]  reg_list_in;
  logic [ADDR_WIDTH-1:0] base_addr_in;
  logic [1:0]            mode_in;
  logic                  ready_in;
  logic                  busy_out;
  logic                  valid_out;
  logic [RIDX_W-1:0]     reg_addr_out;
  logic [ADDR_WIDTH-1:0] mem_addr_out;
  logic                  last_out;
  logic                  done_out;
`ifdef LDM_STM_WRITEBACK_EN
  logic [ADDR_WIDTH-1:0] wb_addr_out;
  logic                  wb_en_out;

  modport master (
    output start_in, reg_list_in, base_addr_in, mode_in, ready_in,
    input  busy_out, valid_out, reg_addr_out, mem_addr_out, last_out, done_out,
    input  wb_addr_out, wb_en_out
  );

  modport slave (
    input  start_in, reg_list_in, base_addr_in, mode_in, ready_in,
    output busy_out, valid_out, reg_addr_out, mem_addr_out, last_out, done_out,
    output wb_addr_out, wb_en_out
  );
`else
  modport master (
    output start_in, reg_list_in, base_addr_in, mode_in, ready_in,
    input  busy_out, valid_out, reg_addr_out, mem_addr_out, last_out, done_out
  );

  modport slave (
    input  start_in, reg_list_in, base_addr_in, mode_in, ready_in,
    output busy_out, valid_out, reg_addr_out, mem_addr_out, last_out, done_out
  );
`endif
endinterface

// File: rtl/ldm_stm_sequencer.sv
// LDM/STM multi-register transfer sequencer: one register/address beat per handshake, lowest index first.
// Define LDM_STM_WRITEBACK_EN to add the base writeback value and strobe.
module ldm_stm_sequencer #(
  parameter int REG_COUNT  = 16,
  parameter int RIDX_W     = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int WORD_BYTES = 4
) (
  input logic                clk_in,
  input logic                reset_in,
  ldm_stm_sequencer_if.slave bus
);

  localparam logic [ADDR_WIDTH-1:0] WB    = ADDR_WIDTH'(WORD_BYTES);
  localparam logic [RIDX_W:0]       ONE   = (RIDX_W+1)'(1);
  localparam logic [RIDX_W:0]       TWO   = (RIDX_W+1)'(2);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                state;
  logic [REG_COUNT-1:0]  list_q;
  logic [RIDX_W:0]       cnt_q;
  logic                  busy_q;
  logic                  valid_q;
  logic [RIDX_W-1:0]     reg_addr_q;
  logic [ADDR_WIDTH-1:0] mem_addr_q;
  logic                  last_q;
  logic                  done_q;

  logic [RIDX_W:0]       start_cnt;
  logic [ADDR_WIDTH-1:0] span;
  logic [ADDR_WIDTH-1:0] start_addr;
  logic [REG_COUNT-1:0]  next_list;

  function automatic logic [RIDX_W-1:0] lowest_idx(input logic [REG_COUNT-1:0] l);
    lowest_idx = '0;
    for (int i = REG_COUNT - 1; i >= 0; i--)
      if (l[i]) lowest_idx = RIDX_W'(i);
  endfunction

  function automatic logic [RIDX_W:0] popcount(input logic [REG_COUNT-1:0] l);
    popcount = '0;
    for (int i = 0; i < REG_COUNT; i++)
      popcount = popcount + (RIDX_W+1)'(l[i]);
  endfunction

  // Decrementing modes start at the bottom of the block so addresses still ascend with index.
  always_comb begin
    start_cnt = popcount(bus.reg_list_in);
    span      = ADDR_WIDTH'(start_cnt) * WB;
    case (bus.mode_in)
      2'b01:   start_addr = bus.base_addr_in;
      2'b11:   start_addr = bus.base_addr_in + WB;
      2'b00:   start_addr = bus.base_addr_in - span + WB;
      default: start_addr = bus.base_addr_in - span;
    endcase
    next_list = list_q;
    next_list[reg_addr_q] = 1'b0;
  end

`ifdef LDM_STM_WRITEBACK_EN
  logic [ADDR_WIDTH-1:0] start_wb;
  logic [ADDR_WIDTH-1:0] wb_q;
  logic [ADDR_WIDTH-1:0] wb_addr_q;
  logic                  wb_en_q;

  always_comb begin
    start_wb = bus.mode_in[0] ? (bus.base_addr_in + span) : (bus.base_addr_in - span);
  end

  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) begin
      wb_q      <= '0;
      wb_addr_q <= '0;
      wb_en_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.start_in) begin
          wb_q <= start_wb;
          if (start_cnt == '0) begin
            wb_addr_q <= start_wb;
            wb_en_q   <= 1'b1;
          end
        end
        RUN: if (bus.ready_in && last_q) begin
          wb_addr_q <= wb_q;
          wb_en_q   <= 1'b1;
        end
        default: begin
          wb_q      <= '0;
          wb_addr_q <= '0;
          wb_en_q   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.wb_addr_out = wb_addr_q;
  assign bus.wb_en_out   = wb_en_q;
`endif

  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) begin
      state      <= IDLE;
      list_q     <= '0;
      cnt_q      <= '0;
      busy_q     <= 1'b0;
      valid_q    <= 1'b0;
      reg_addr_q <= '0;
      mem_addr_q <= '0;
      last_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.start_in) begin
          busy_q <= 1'b1;
          list_q <= bus.reg_list_in;
          cnt_q  <= start_cnt;
          if (start_cnt != '0) begin
            state      <= RUN;
            valid_q    <= 1'b1;
            reg_addr_q <= lowest_idx(bus.reg_list_in);
            mem_addr_q <= start_addr;
            last_q     <= (start_cnt == ONE);
          end else begin
            state  <= DONE;
            done_q <= 1'b1;
          end
        end
        RUN: if (bus.ready_in) begin
          if (last_q) begin
            state      <= DONE;
            valid_q    <= 1'b0;
            reg_addr_q <= '0;
            mem_addr_q <= '0;
            last_q     <= 1'b0;
            list_q     <= '0;
            cnt_q      <= '0;
            done_q     <= 1'b1;
          end else begin
            list_q     <= next_list;
            cnt_q      <= cnt_q - ONE;
            reg_addr_q <= lowest_idx(next_list);
            mem_addr_q <= mem_addr_q + WB;
            last_q     <= (cnt_q == TWO);
          end
        end
        DONE: begin
          state  <= IDLE;
          busy_q <= 1'b0;
          done_q <= 1'b0;
          list_q <= '0;
          cnt_q  <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy_out     = busy_q;
  assign bus.valid_out    = valid_q;
  assign bus.reg_addr_out = reg_addr_q;
  assign bus.mem_addr_out = mem_addr_q;
  assign bus.last_out     = last_q;
  assign bus.done_out     = done_q;

endmodule

// File: tb/tb_ldm_stm_sequencer.sv
// Scoreboard bench for ldm_stm_sequencer; expected beats are queued at start and popped on each handshake.
// Define LDM_STM_WRITEBACK_EN to also check the writeback outputs.
module tb_ldm_stm_sequencer;

  localparam int WB = 4;

  typedef struct packed {
    logic [3:0]  reg_idx;
    logic [31:0] addr;
    logic        last;
  } beat_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  ldm_stm_sequencer_if bus ();

  ldm_stm_sequencer dut (
    .clk_in   (clk),
    .reset_in (rst_n),
    .bus      (bus)
  );

  beat_t       exp_q[$];
  beat_t       held;
  beat_t       got;
  bit          hold_pending = 1'b0;
  bit          mon_en       = 1'b0;
  int          checks       = 0;
  int          errors       = 0;
  int          beats_seen   = 0;
  int          valid_cycles = 0;
  logic [31:0] exp_wb;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, want 0x%08h", tag, observed, expected);
    end
  endtask

  // Beat monitor: pops the scoreboard on every handshake and checks stability across stalls.
  always @(negedge clk) begin
    if (mon_en) begin
      if (hold_pending) begin
        checkOutput("hold_valid", bus.valid_out, 1);
        checkOutput("hold_reg", bus.reg_addr_out, held.reg_idx);
        checkOutput("hold_addr", bus.mem_addr_out, held.addr);
        checkOutput("hold_last", bus.last_out, held.last);
        hold_pending = 1'b0;
      end
      if (bus.valid_out) begin
        valid_cycles++;
        if (bus.ready_in) begin
          if (exp_q.size() == 0) begin
            checkOutput("unexpected_beat", bus.reg_addr_out, 32'hFFFF_FFFF);
          end else begin
            got = exp_q.pop_front();
            checkOutput("beat_reg", bus.reg_addr_out, got.reg_idx);
            checkOutput("beat_addr", bus.mem_addr_out, got.addr);
            checkOutput("beat_last", bus.last_out, got.last);
          end
          beats_seen++;
        end else begin
          held         = '{bus.reg_addr_out, bus.mem_addr_out, bus.last_out};
          hold_pending = 1'b1;
        end
      end
    end
  end

  task automatic applyStimulus(input logic [15:0] list, input logic [31:0] base,
                               input logic [1:0] mode, input int stall_beat, input int stall_cycles);
    int          n;
    int          remaining;
    int          stalled;
    int          cyc;
    logic [31:0] addr;
    logic [31:0] span;
    n = 0;
    for (int i = 0; i < 16; i++) if (list[i]) n++;
    span = 32'(n * WB);
    case (mode)
      2'b01:   addr = base;
      2'b11:   addr = base + 32'(WB);
      2'b00:   addr = base - span + 32'(WB);
      default: addr = base - span;
    endcase
    remaining = n;
    for (int i = 0; i < 16; i++) begin
      if (list[i]) begin
        remaining--;
        exp_q.push_back('{4'(i), addr, remaining == 0});
        addr = addr + 32'(WB);
      end
    end
    exp_wb       = mode[0] ? (base + span) : (base - span);
    beats_seen   = 0;
    valid_cycles = 0;
    stalled      = 0;

    @(posedge clk); #1;
    bus.start_in     = 1'b1;
    bus.reg_list_in  = list;
    bus.base_addr_in = base;
    bus.mode_in      = mode;
    bus.ready_in     = 1'b1;
    @(posedge clk); #1;
    bus.start_in     = 1'b0;
    bus.reg_list_in  = 16'($urandom);
    bus.base_addr_in = $urandom;
    bus.mode_in      = 2'($urandom);
    bus.ready_in     = !(beats_seen == stall_beat && stalled < stall_cycles);
    if (!bus.ready_in) stalled++;
    @(negedge clk);
    if (n > 0) checkOutput("first_valid_latency", bus.valid_out, 1);
    else       checkOutput("empty_done_cycle1", bus.done_out, 1);

    cyc = 0;
    while (!bus.done_out && cyc < 200) begin
      @(posedge clk); #1;
      bus.start_in     = 1'($urandom_range(0, 1));
      bus.reg_list_in  = 16'($urandom);
      bus.base_addr_in = $urandom;
      bus.mode_in      = 2'($urandom);
      bus.ready_in     = !(beats_seen == stall_beat && stalled < stall_cycles);
      if (!bus.ready_in) stalled++;
      @(negedge clk);
      cyc++;
    end
    bus.start_in = 1'b0;

    checkOutput("done_seen", bus.done_out, 1);
    checkOutput("beat_count", beats_seen, n);
    checkOutput("valid_cycles", valid_cycles, n + stalled);
    checkOutput("queue_drained", exp_q.size(), 0);
    checkOutput("busy_in_done", bus.busy_out, 1);
    checkOutput("valid_in_done", bus.valid_out, 0);
`ifdef LDM_STM_WRITEBACK_EN
    checkOutput("wb_addr", bus.wb_addr_out, exp_wb);
    checkOutput("wb_en", bus.wb_en_out, 1);
`endif
    @(negedge clk);
    checkOutput("done_one_cycle", bus.done_out, 0);
    checkOutput("idle_not_busy", bus.busy_out, 0);
`ifdef LDM_STM_WRITEBACK_EN
    checkOutput("wb_en_clear", bus.wb_en_out, 0);
    checkOutput("wb_addr_clear", bus.wb_addr_out, 0);
`endif
    exp_q.delete();
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_busy"}, bus.busy_out, 0);
    checkOutput({tag, "_valid"}, bus.valid_out, 0);
    checkOutput({tag, "_reg"}, bus.reg_addr_out, 0);
    checkOutput({tag, "_addr"}, bus.mem_addr_out, 0);
    checkOutput({tag, "_last"}, bus.last_out, 0);
    checkOutput({tag, "_done"}, bus.done_out, 0);
`ifdef LDM_STM_WRITEBACK_EN
    checkOutput({tag, "_wb_addr"}, bus.wb_addr_out, 0);
    checkOutput({tag, "_wb_en"}, bus.wb_en_out, 0);
`endif
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bus.start_in     = 1'b0;
    bus.reg_list_in  = '0;
    bus.base_addr_in = '0;
    bus.mode_in      = '0;
    bus.ready_in     = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    checkAllZero("reset");
    @(negedge clk);
    rst_n  = 1'b1;
    mon_en = 1'b1;

    applyStimulus(16'h8001, 32'h0000_1000, 2'b01, -1, 0);
    applyStimulus(16'h00F0, 32'h0000_2000, 2'b10, -1, 0);
    applyStimulus(16'h0006, 32'h0000_1000, 2'b11, 0, 3);
    applyStimulus(16'h0000, 32'h0000_5555, 2'b00, -1, 0);
    applyStimulus(16'h0003, 32'hFFFF_FFFC, 2'b11, -1, 0);
    applyStimulus(16'h0A05, 32'h0000_0100, 2'b00, 2, 2);
    applyStimulus(16'hFFFF, 32'h0000_0008, 2'b10, 15, 1);
    for (int k = 0; k < 4; k++)
      applyStimulus(16'($urandom), $urandom, 2'($urandom), int'($urandom_range(0, 3)), int'($urandom_range(0, 2)));

    mon_en = 1'b0;
    @(posedge clk); #1;
    bus.start_in     = 1'b1;
    bus.reg_list_in  = 16'hFFFF;
    bus.base_addr_in = 32'h0000_4000;
    bus.mode_in      = 2'b01;
    bus.ready_in     = 1'b1;
    @(posedge clk); #1;
    bus.start_in = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("pre_reset_busy", bus.busy_out, 1);
    checkOutput("pre_reset_addr", bus.mem_addr_out, 32'h0000_400C);
    #2;
    rst_n = 1'b0;
    #1;
    checkAllZero("async_reset");
    @(negedge clk);
    checkOutput("reset_no_done", bus.done_out, 0);
    rst_n  = 1'b1;
    mon_en = 1'b1;

    applyStimulus(16'h0410, 32'h0000_3000, 2'b01, -1, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
